wb_trace_buffer: RTL and testbench

- Downstream consumer of the core's final writeback port (write enable, 5-bit register address, 16-bit value).
- Stamps every retired writeback with a sequence number and buffers it in a FIFO.
- Drains entries over a valid/ready handshake to a debug or trace sink.
- Never back-pressures the core. If the buffer is full, entries are dropped and counted, and the consumer detects the loss as sequence gaps.

---
 rtl/pa_trace_pkg.sv | 22 ++
 rtl/wb_trace_buffer_sync_fifo.sv | 53 +++++
 rtl/wb_trace_buffer.sv | 82 ++++++++
 tb/tb_wb_trace_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pa_trace_pkg.sv
// Shared types and widths for the writeback trace path: the writeback fields,
// the packed trace entry layout and a helper that sizes an entry for any seq width.
package pa_trace_pkg;

    localparam int WB_ADDR_W   = 5;
    localparam int WB_DATA_W   = 16;
    localparam int SEQ_W_DEF   = 16;

    // Seq sits in the MSBs so a sink can read ordering without unpacking the rest.
    typedef struct packed {
        logic [SEQ_W_DEF-1:0] seq;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] val;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

    function automatic int trace_w(input int seq_w);
        return seq_w + WB_ADDR_W + WB_DATA_W;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO with extra-bit pointers, a flush that empties in one
// cycle, and unreset storage whose visibility is governed purely by the pointers.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Stamps each retired writeback with a sequence number and queues it for a trace
// sink; never stalls the core, and counts whatever it has to drop.
module wb_trace_buffer
    import pa_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            wb_valid_i,
    input  logic [WB_ADDR_W-1:0]            wb_addr_i,
    input  logic [WB_DATA_W-1:0]            wb_val_i,
    input  logic                            flush_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [trace_w(SEQ_W)-1:0]       out_data_o,
    output logic [$clog2(DEPTH):0]          level_o,
    output logic [DROP_W-1:0]               drop_count_o,
    output logic                            overflow_o
);

    localparam int TW = trace_w(SEQ_W);
    localparam logic [SEQ_W-1:0]  SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [SEQ_W-1:0]  seq_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              drop;
    logic [TW-1:0]     head;
    logic [TW-1:0]     entry;

    assign entry = {seq_q, wb_addr_i, wb_val_i};

    // Flush wins over both sides; a flushed event is discarded, not counted as a drop.
    assign pop  = !fifo_empty && out_ready_i && !flush_i;
    assign push = wb_valid_i && !flush_i && (!fifo_full || pop);
    assign drop = wb_valid_i && !flush_i && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (reset_i),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .wdata (entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            seq_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wb_valid_i) seq_q <= seq_q + SEQ_ONE;
            if (drop) begin
                if (drop_q != '1) drop_q <= drop_q + DROP_ONE;
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is never reset, so the head is masked whenever nothing is queued.
    assign out_valid_o  = !fifo_empty;
    assign out_data_o   = fifo_empty ? '0 : head;
    assign drop_count_o = drop_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed and randomized bench for wb_trace_buffer against a queue-based model.
module tb_wb_trace_buffer;
    import pa_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [15:0] wb_val_i = '0;
    logic        flush_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [36:0] out_data_o;
    logic [4:0]  level_o;
    logic [7:0]  drop_count_o;
    logic        overflow_o;

    wb_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(16), .DROP_W(8)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .wb_valid_i   (wb_valid_i),
        .wb_addr_i    (wb_addr_i),
        .wb_val_i     (wb_val_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .level_o      (level_o),
        .drop_count_o (drop_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_fails  = 0;

    logic [36:0] mq[$];
    int          mseq;
    int          mdrop;
    bit          movf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mseq = 0;
        mdrop = 0;
        movf = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [4:0] a, input logic [15:0] d,
                              input bit rdy, input bit fl);
        logic [15:0] s;
        s = mseq[15:0];
        if (fl) begin
            mq.delete();
        end else begin
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({s, a, d});
                end else begin
                    if (mdrop < 255) mdrop++;
                    movf = 1'b1;
                end
            end
        end
        if (v) mseq = (mseq + 1) % 65536;
    endtask

    task automatic check_model(input string tag);
        logic [36:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : 37'd0;
        chk({tag, ".level"}, 64'(level_o), 64'(mq.size()));
        chk({tag, ".valid"}, 64'(out_valid_o), 64'(mq.size() != 0));
        chk({tag, ".data"},  64'(out_data_o), 64'(exp_data));
        chk({tag, ".drops"}, 64'(drop_count_o), 64'(mdrop));
        chk({tag, ".ovf"},   64'(overflow_o), 64'(movf));
    endtask

    // Drives one cycle: inputs applied now, model advanced at the edge, outputs sampled 1 after.
    task automatic cycle(input bit v, input logic [4:0] a, input logic [15:0] d,
                         input bit rdy, input bit fl, input string tag);
        wb_valid_i  = v;
        wb_addr_i   = a;
        wb_val_i    = d;
        out_ready_i = rdy;
        flush_i     = fl;
        @(posedge clock_i);
        model_step(v, a, d, rdy, fl);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        wb_valid_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        reset_i = 1'b0;
        repeat (3) @(posedge clock_i);
        model_reset();
        #1;
        check_model("reset");
        @(negedge clock_i);
        reset_i = 1'b1;
    endtask

    initial begin
        logic [7:0]  drops_before;
        logic [15:0] seq_before;
        trace_entry_t e;

        model_reset();
        // Reset then idle
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, "idle");
        chk("idle.level", 64'(level_o), 64'd0);

        // Single event
        cycle(1'b1, 5'd5, 16'h1234, 1'b0, 1'b0, "single");
        chk("single.valid", 64'(out_valid_o), 64'd1);
        chk("single.data", 64'(out_data_o), 64'({16'd0, 5'd5, 16'h1234}));
        cycle(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, "single_pop");
        chk("single.level0", 64'(level_o), 64'd0);

        // Overflow with 18 events into a stalled sink
        do_reset();
        for (int i = 0; i < 18; i++) cycle(1'b1, 5'(i), 16'(i), 1'b0, 1'b0, "ovf_fill");
        chk("ovf.level", 64'(level_o), 64'd16);
        chk("ovf.drops", 64'(drop_count_o), 64'd2);
        chk("ovf.flag",  64'(overflow_o), 64'd1);

        // Full with simultaneous push and pop
        cycle(1'b1, 5'd9, 16'hBEEF, 1'b1, 1'b0, "full_pp");
        chk("full_pp.level", 64'(level_o), 64'd16);
        chk("full_pp.drops", 64'(drop_count_o), 64'd2);

        // Drain: seq 1..15 remain, then the 0xBEEF tail carrying seq 18
        for (int i = 1; i < 16; i++) begin
            e = trace_entry_t'(out_data_o);
            chk("drain.seq", 64'(e.seq), 64'(i));
            chk("drain.val", 64'(e.val), 64'(i));
            cycle(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, "drain");
        end
        e = trace_entry_t'(out_data_o);
        chk("tail.seq", 64'(e.seq), 64'd18);
        chk("tail.val", 64'(e.val), 64'hBEEF);
        cycle(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, "drain_last");
        chk("drain.empty", 64'(out_valid_o), 64'd0);

        // Flush collision: level 4, flush with event and ready
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd1, 16'(100 + i), 1'b0, 1'b0, "fl_fill");
        chk("fl.level4", 64'(level_o), 64'd4);
        drops_before = drop_count_o;
        seq_before = 16'(mseq);
        cycle(1'b1, 5'd2, 16'h5555, 1'b1, 1'b1, "flush");
        chk("flush.level", 64'(level_o), 64'd0);
        chk("flush.valid", 64'(out_valid_o), 64'd0);
        chk("flush.drops", 64'(drop_count_o), 64'(drops_before));
        cycle(1'b1, 5'd3, 16'hAAAA, 1'b0, 1'b0, "post_flush");
        e = trace_entry_t'(out_data_o);
        chk("post_flush.seq", 64'(e.seq), 64'(seq_before + 16'd1));

        // Drop counter saturation
        for (int i = 0; i < 280; i++) cycle(1'b1, 5'd4, 16'(i), 1'b0, 1'b0, "sat");
        chk("sat.drops", 64'(drop_count_o), 64'd255);

        // Async reset mid-burst with level 7
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 5'd6, 16'(i), 1'b0, 1'b0, "burst");
        chk("burst.level7", 64'(level_o), 64'd7);
        #3;
        reset_i = 1'b0;
        #1;
        model_reset();
        chk("areset.level", 64'(level_o), 64'd0);
        chk("areset.valid", 64'(out_valid_o), 64'd0);
        chk("areset.data",  64'(out_data_o), 64'd0);
        chk("areset.drops", 64'(drop_count_o), 64'd0);
        @(negedge clock_i);
        reset_i = 1'b1;
        cycle(1'b1, 5'd7, 16'h7777, 1'b0, 1'b0, "after_rst");
        chk("after_rst.data", 64'(out_data_o), 64'({16'd0, 5'd7, 16'h7777}));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 6), 5'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 3 : 7)),
                  ($urandom_range(0, 49) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
